// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IR capture with a valid/ready handshake and redirect.
// Optional halt detection is compiled in when FETCH_HALT_EN is defined.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] imem_adr,
  input  logic [15:0] imem_q,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        ready,
  output logic        valid,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        halted
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
`ifdef FETCH_HALT_EN
  localparam logic [1:0] HALT = 2'd2;
`endif

  logic [1:0]  state;
  logic [15:0] pc;
  logic        capture_halt;

  // The memory is read on the falling edge, so the address must come straight from pc.
  assign imem_adr = pc;

`ifdef FETCH_HALT_EN
  assign capture_halt = (imem_q[15:12] == HALT_OPCODE);
  assign halted       = (state == HALT);
`else
  assign capture_halt = 1'b0;
  assign halted       = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc    <= RESET_PC;
      state <= RUN;
      valid <= 1'b0;
      ir    <= 16'h0000;
      ir_pc <= 16'h0000;
    end else if (redirect) begin
      // Redirect beats every state and the handshake; the word in flight is dropped.
      pc    <= redirect_pc;
      valid <= 1'b0;
      state <= RUN;
`ifdef FETCH_HALT_EN
    end else if (state == HALT) begin
      if (valid && ready)
        valid <= 1'b0;
`endif
    end else if (valid && !ready) begin
      state <= HOLD;
    end else begin
      ir    <= imem_q;
      ir_pc <= pc;
      valid <= 1'b1;
      pc    <= pc + 16'd1;
`ifdef FETCH_HALT_EN
      state <= capture_halt ? HALT : RUN;
`else
      state <= RUN;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, HOLD, redirect, PC wrap, reset in HOLD and,
// when FETCH_HALT_EN is defined, halt detection.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ready;
  logic [15:0] imem_adr, imem_q;
  logic        valid, halted;
  logic [15:0] ir, ir_pc;

  logic [15:0] imem_adr2, imem_q2;
  logic        valid2, halted2;
  logic [15:0] ir2, ir_pc2;

  logic [15:0] mem [0:255];
  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .CLK(CLK), .RST(RST), .imem_adr(imem_adr), .imem_q(imem_q),
    .redirect(redirect), .redirect_pc(redirect_pc), .ready(ready),
    .valid(valid), .ir(ir), .ir_pc(ir_pc), .halted(halted)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) dut2 (
    .CLK(CLK), .RST(RST), .imem_adr(imem_adr2), .imem_q(imem_q2),
    .redirect(1'b0), .redirect_pc(16'h0000), .ready(1'b1),
    .valid(valid2), .ir(ir2), .ir_pc(ir_pc2), .halted(halted2)
  );

  // Instruction memory clocked on the falling edge.
  always @(negedge CLK) begin
    imem_q  <= mem[imem_adr[7:0]];
    imem_q2 <= mem[imem_adr2[7:0]];
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic redir, input logic [15:0] rpc);
    RST         = rst;
    ready       = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    RST = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;

    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("rst_valid",  {15'b0, valid}, 16'h0000);
    checkOutput("rst_ir",     ir,             16'h0000);
    checkOutput("rst_ir_pc",  ir_pc,          16'h0000);
    checkOutput("rst_adr",    imem_adr,       16'h0000);
    checkOutput("rst_halted", {15'b0, halted}, 16'h0000);
    checkOutput("rst_adr2",   imem_adr2,      16'hFFFE);

    // Stream three words; dut2 wraps its PC through 0xFFFF.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      checkOutput($sformatf("run_ir%0d", k),    ir,    16'h1000 + 16'(k));
      checkOutput($sformatf("run_pc%0d", k),    ir_pc, 16'(k));
      checkOutput($sformatf("run_valid%0d", k), {15'b0, valid}, 16'h0001);
      checkOutput($sformatf("wrap_pc%0d", k),   ir_pc2, 16'hFFFE + 16'(k));
    end

    // Three stalled cycles with ir_pc=2.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("hold_ir%0d", k),  ir,       16'h1002);
      checkOutput($sformatf("hold_pc%0d", k),  ir_pc,    16'h0002);
      checkOutput($sformatf("hold_adr%0d", k), imem_adr, 16'h0003);
      checkOutput($sformatf("hold_v%0d", k),   {15'b0, valid}, 16'h0001);
    end
    for (int k = 3; k < 6; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      checkOutput($sformatf("resume_pc%0d", k), ir_pc, 16'(k));
      checkOutput($sformatf("resume_ir%0d", k), ir,    16'h1000 + 16'(k));
    end

    // Redirect to 3 while stalled at ir_pc=5.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0003);
    checkOutput("redir_valid",  {15'b0, valid}, 16'h0000);
    checkOutput("redir_adr",    imem_adr,       16'h0003);
    checkOutput("redir_ir_hold", ir,            16'h1005);
    checkOutput("redir_pc_hold", ir_pc,         16'h0005);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("redir_first_pc", ir_pc, 16'h0003);
    checkOutput("redir_first_ir", ir,    16'h1003);
    checkOutput("redir_first_v",  {15'b0, valid}, 16'h0001);

`ifdef FETCH_HALT_EN
    mem[4] = 16'hF000;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("halt_ir",     ir,             16'hF000);
    checkOutput("halt_ir_pc",  ir_pc,          16'h0004);
    checkOutput("halt_valid",  {15'b0, valid}, 16'h0001);
    checkOutput("halt_flag",   {15'b0, halted}, 16'h0001);
    checkOutput("halt_adr",    imem_adr,       16'h0005);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      checkOutput($sformatf("halted_v%0d", k),   {15'b0, valid}, 16'h0000);
      checkOutput($sformatf("halted_f%0d", k),   {15'b0, halted}, 16'h0001);
      checkOutput($sformatf("halted_adr%0d", k), imem_adr, 16'h0005);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000);
    checkOutput("unhalt_flag", {15'b0, halted}, 16'h0000);
    checkOutput("unhalt_adr",  imem_adr,        16'h0000);
    mem[4] = 16'h1004;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("unhalt_pc", ir_pc, 16'h0000);
    checkOutput("unhalt_ir", ir,    16'h1000);
    checkOutput("unhalt_v",  {15'b0, valid}, 16'h0001);
`else
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("seq_pc4",   ir_pc, 16'h0004);
    checkOutput("seq_ir4",   ir,    16'h1004);
    checkOutput("no_halted", {15'b0, halted}, 16'h0000);
`endif

    // Reset while holding a live instruction.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("prerst_valid", {15'b0, valid}, 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0009);
    checkOutput("holdrst_valid",  {15'b0, valid}, 16'h0000);
    checkOutput("holdrst_adr",    imem_adr,       16'h0000);
    checkOutput("holdrst_halted", {15'b0, halted}, 16'h0000);
    checkOutput("holdrst_ir",     ir,             16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("postrst_ir",    ir,    16'h1000);
    checkOutput("postrst_ir_pc", ir_pc, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
